if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage: owns the PC register, drives the instruction-memory address, and holds the IF/ID pipeline register. It sits directly upstream of the load-use hazard unit. Its IF/ID RS/RT fields feed that unit, and it consumes the unit's PC-stall and IF/ID-stall outputs. It also applies branch/jump redirects resolved in ID and keeps a saturating stall-cycle counter for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the stall-cycle counter
NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  run enable; low freezes PC and inserts bubbles
pc_stall_i  in  1  hold PC (from hazard unit PC-stall output)
ifid_stall_i  in  1  hold IF/ID register (from hazard unit IF/ID-stall output)
branch_i  in  1  taken branch resolved in ID this cycle
branch_target_i  in  32  branch target address
jump_i  in  1  jump resolved in ID this cycle
jump_target_i  in  32  jump target address
imem_addr_o  out  32  instruction-memory address (= current PC)
imem_data_i  in  32  instruction word, combinational read of imem_addr_o
ifid_pc4_o  out  32  registered PC+4 of the instruction in ID
ifid_instr_o  out  32  registered instruction in ID
ifid_rs_o  out  5  ifid_instr_o[25:21], to hazard unit
ifid_rt_o  out  5  ifid_instr_o[20:16], to hazard unit
ifid_valid_o  out  1  1 = ID holds a real instruction, 0 = bubble
stall_cnt_o  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst_i=1 at edge):
  - PC<=RESET_PC; ifid_instr_o<=NOP_INSTR; ifid_pc4_o<=0; ifid_valid_o<=0; stall_cnt_o<=0.
  - Reset mid-operation discards all in-flight state, including any redirect in the same cycle.
- imem_addr_o = PC (combinational).
- pc4 = PC+32'd4, modulo 2^32: PC=32'hFFFF_FFFC wraps to 0.
- Per-edge priority when not in reset:
  1. start_i=0: PC holds; IF/ID<=bubble (NOP_INSTR, valid=0, pc4=0); counter holds.
  2. Redirect when (branch_i|jump_i)=1 and ifid_stall_i=0:
     - PC<=branch_target_i if branch_i=1, else jump_target_i. Branch wins if both are asserted; that case is illegal and flagged by a bench assertion.
     - IF/ID<=bubble (flushes the wrong-path fetch). pc_stall_i is ignored this cycle.
  3. Redirect while ifid_stall_i=1: the redirect is ignored, because the branch/jump in ID is itself stalled and will reassert next cycle.
  4. Normal operation:
     - PC<=pc4 unless pc_stall_i=1, in which case PC holds.
     - IF/ID<={imem_data_i, pc4, valid=1} unless ifid_stall_i=1, in which case IF/ID holds all fields including valid.
     - The two stall inputs act independently. pc_stall_i=1 with ifid_stall_i=0 re-latches the same PC's instruction (legal, duplicate fetch).
- Latency:
  - An instruction at PC appears on ifid_instr_o one edge after the PC is presented.
  - A redirect target's instruction reaches ID two edges after branch_i is sampled.
  - Branch penalty is one bubble.
- ifid_rs_o/ifid_rt_o are pure slices of the registered instruction. A bubble yields 0/0, so a load to $0 stalls spuriously. This is accepted: loads to $0 do not occur.
- stall_cnt_o:
  - +1 on each edge where start_i=1, rst_i=0, ifid_stall_i=1 and no redirect is taken.
  - Saturates at 2^CNT_W-1 (no wrap).
- No internal FSM beyond the registers above; every output is registered except imem_addr_o.

Decomposition:
- Shared package cpu_pkg:
  - Field positions RS_MSB=25, RS_LSB=21, RT_MSB=20, RT_LSB=16.
  - NOP_INSTR constant and RESET_PC default; the CPU top also uses these for the ID/EX bubble mux.
- One natural sub-module, pipe_reg: parameterised width, enable (hold) and synchronous clear (bubble value input). Instantiated for the PC and for the IF/ID bundle {pc4, instr, valid}. The counter stays inline.

Test Plan:
- Reset then start_i=1, imem returns 32'h8C01_0000 at PC 0 -> after 1 edge ifid_instr_o=32'h8C01_0000, ifid_pc4_o=4, ifid_rs_o=0, ifid_rt_o=1, valid=1; PC=4.
- Load-use: pc_stall_i=ifid_stall_i=1 for one cycle at PC=8 -> PC stays 8, IF/ID unchanged, stall_cnt_o 0->1; next edge PC=12.
- branch_i=1, target 32'h40 at PC=16 -> next edge PC=32'h40, ifid_instr_o=0, valid=0; following edge ifid_pc4_o=32'h44, valid=1.
- branch_i=1 with ifid_stall_i=1 -> branch ignored, PC/IF-ID held; branch reasserted next cycle with stall low -> PC=target.
- CNT_W=4, ifid_stall_i held 20 cycles -> stall_cnt_o saturates at 15 and stays 15.
- rst_i=1 mid-run with jump_i=1 same cycle, and start_i=0 for 3 cycles -> reset values win over the jump; while start_i=0, PC is frozen at RESET_PC and ifid_valid_o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, bubble/reset constants
// and the IF/ID pipeline-register bundle.
package cpu_pkg;

  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  // sll $0,$0,0 -- used as the bubble word in IF/ID and ID/EX
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_SEQ,
    PC_BRANCH,
    PC_JUMP
  } pc_src_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous reset, synchronous clear to a
// caller-supplied bubble value, and enable (hold when low).
module pipe_reg #(
  parameter int unsigned      W       = 32,
  parameter logic [W-1:0]     RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] clr_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= RST_VAL;
    end else if (clr_i) begin
      q_o <= clr_val_i;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address, IF/ID
// pipeline register, branch/jump redirect and saturating stall-cycle counter.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_C,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pc_stall_i,
  input  logic             ifid_stall_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      ifid_pc4_o,
  output logic [31:0]      ifid_instr_o,
  output logic [4:0]       ifid_rs_o,
  output logic [4:0]       ifid_rt_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam ifid_t IFID_BUBBLE = '{pc4: '0, instr: NOP_INSTR, valid: 1'b0};
  localparam int unsigned IFID_W = $bits(ifid_t);

  pc_src_e     pc_src;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc4;
  logic        redirect;
  logic        pc_en;
  logic        ifid_clr;
  logic        ifid_en;
  ifid_t       ifid_d;
  ifid_t       ifid_q;
  logic        cnt_inc;

  assign pc4         = pc_plus4(pc_q);
  assign imem_addr_o = pc_q;

  // A redirect is only honoured when the branch/jump in ID is not itself stalled.
  assign redirect = start_i & (branch_i | jump_i) & ~ifid_stall_i;

  always_comb begin
    pc_src = PC_HOLD;
    if (start_i) begin
      if (redirect) begin
        pc_src = branch_i ? PC_BRANCH : PC_JUMP;
      end else if (!pc_stall_i) begin
        pc_src = PC_SEQ;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (pc_src)
      PC_HOLD:   pc_d = pc_q;
      PC_SEQ:    pc_d = pc4;
      PC_BRANCH: pc_d = branch_target_i;
      PC_JUMP:   pc_d = jump_target_i;
      default:   pc_d = pc_q;
    endcase
  end

  assign pc_en = (pc_src != PC_HOLD);

  pipe_reg #(
    .W       (32),
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (pc_en),
    .clr_i     (1'b0),
    .clr_val_i (RESET_PC),
    .d_i       (pc_d),
    .q_o       (pc_q)
  );

  // Idle or redirect squashes the fetch; otherwise ifid_stall_i holds all fields.
  assign ifid_clr = ~start_i | redirect;
  assign ifid_en  = ~ifid_stall_i;

  always_comb begin
    ifid_d       = IFID_BUBBLE;
    ifid_d.pc4   = pc4;
    ifid_d.instr = imem_data_i;
    ifid_d.valid = 1'b1;
  end

  pipe_reg #(
    .W       (IFID_W),
    .RST_VAL (IFID_BUBBLE)
  ) u_ifid_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (ifid_en),
    .clr_i     (ifid_clr),
    .clr_val_i (IFID_BUBBLE),
    .d_i       (ifid_d),
    .q_o       (ifid_q)
  );

  assign ifid_pc4_o   = ifid_q.pc4;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_valid_o = ifid_q.valid;
  assign ifid_rs_o    = ifid_q.instr[RS_MSB:RS_LSB];
  assign ifid_rt_o    = ifid_q.instr[RT_MSB:RT_LSB];

  assign cnt_inc = start_i & ifid_stall_i & ~redirect;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (cnt_inc && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule
